rc4_prga: RTL and testbench

//  RC4 keystream generator and en/decoder: the consumer of the key-scheduling stage.

---
 rtl/rc4_pkg.sv | 32 +++
 rtl/rc4_sbox.sv | 46 ++++
 rtl/rc4_prga.sv | 218 +++++++++++++++++++++
 tb/tb_rc4_prga.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rc4_pkg.sv
// Shared RC4 definitions used by the key scheduler and the keystream generator.
package rc4_pkg;

  localparam int unsigned SBOX_DEPTH = 256;
  localparam int unsigned BYTE_W     = 8;

  typedef logic [BYTE_W-1:0] byte_t;

  // Top-level operating modes of the RC4 engine (key scheduler side).
  typedef enum logic [1:0] {
    INIT       = 2'd0,
    KEY_GENE   = 2'd1,
    EN_DE_CODE = 2'd2
  } rc4_mode_e;

  // Keystream generator states.
  typedef enum logic [2:0] {
    StLoad = 3'd0,
    StDrop = 3'd1,
    StIdle = 3'd2,
    StG1   = 3'd3,
    StG2   = 3'd4,
    StG3   = 3'd5,
    StOut  = 3'd6
  } prga_state_e;

  // Mod-256 index sum; the carry is discarded on purpose.
  function automatic byte_t idx_add(input byte_t a, input byte_t b);
    return a + b;
  endfunction

endpackage

// File: rtl/rc4_sbox.sv
// 256x8 RC4 state array: two asynchronous read ports, two write ports,
// identity contents after reset or a synchronous clear.
module rc4_sbox
  import rc4_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic [BYTE_W-1:0] i_rd_a_addr,
  output logic [BYTE_W-1:0] o_rd_a_data,
  input  logic [BYTE_W-1:0] i_rd_b_addr,
  output logic [BYTE_W-1:0] o_rd_b_data,
  input  logic              i_wr_a_en,
  input  logic [BYTE_W-1:0] i_wr_a_addr,
  input  logic [BYTE_W-1:0] i_wr_a_data,
  input  logic              i_wr_b_en,
  input  logic [BYTE_W-1:0] i_wr_b_addr,
  input  logic [BYTE_W-1:0] i_wr_b_data
);

  logic [BYTE_W-1:0] r_mem [SBOX_DEPTH];

  // Array update: identity on reset/clear; port B is written last so it wins a collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int m = 0; m < SBOX_DEPTH; m++) begin
        r_mem[m] <= BYTE_W'(m);
      end
    end else if (i_clear) begin
      for (int m = 0; m < SBOX_DEPTH; m++) begin
        r_mem[m] <= BYTE_W'(m);
      end
    end else begin
      if (i_wr_a_en) begin
        r_mem[i_wr_a_addr] <= i_wr_a_data;
      end
      if (i_wr_b_en) begin
        r_mem[i_wr_b_addr] <= i_wr_b_data;
      end
    end
  end

  assign o_rd_a_data = r_mem[i_rd_a_addr];
  assign o_rd_b_data = r_mem[i_rd_b_addr];

endmodule

// File: rtl/rc4_prga.sv
// RC4 keystream generator (PRGA) with XOR en/decoder and optional RC4-drop[N].
// S-box is loaded byte-by-byte in LOAD, then each accepted input byte walks
// G1 (advance i, fetch S[i], advance j), G2 (swap), G3 (XOR) and waits in OUT.
module rc4_prga
  import rc4_pkg::*;
#(
  parameter int unsigned DROP_N = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_sbox_wr_en,
  input  logic [BYTE_W-1:0] i_sbox_wr_addr,
  input  logic [BYTE_W-1:0] i_sbox_wr_data,
  input  logic              i_start,
  input  logic              i_restart,
  input  logic              i_din_valid,
  output logic              o_din_ready,
  input  logic [BYTE_W-1:0] i_din,
  output logic              o_dout_valid,
  input  logic              i_dout_ready,
  output logic [BYTE_W-1:0] o_dout,
  output logic              o_busy
);

  localparam bit         HasDrop  = (DROP_N != 0);
  localparam logic [9:0] DropLast = 10'(DROP_N - 1);

  prga_state_e       r_state, w_state_d;
  logic [BYTE_W-1:0] r_i, w_i_d;
  logic [BYTE_W-1:0] r_j, w_j_d;
  logic [BYTE_W-1:0] r_si, w_si_d;
  logic [BYTE_W-1:0] r_sj, w_sj_d;
  logic [BYTE_W-1:0] r_din, w_din_d;
  logic [BYTE_W-1:0] r_dout, w_dout_d;
  logic              r_dout_valid, w_dout_valid_d;
  logic [9:0]        r_drop_cnt, w_drop_cnt_d;
  logic [1:0]        r_phase, w_phase_d;

  logic [BYTE_W-1:0] w_i_inc;
  logic              w_do_g1;
  logic              w_do_g2;

  logic [BYTE_W-1:0] w_rd_a_addr, w_rd_a_data;
  logic [BYTE_W-1:0] w_rd_b_addr, w_rd_b_data;
  logic              w_wr_a_en, w_wr_b_en;
  logic [BYTE_W-1:0] w_wr_a_addr, w_wr_a_data;
  logic [BYTE_W-1:0] w_wr_b_addr, w_wr_b_data;
  logic              w_clear;

  // The G1 and G2 steps are shared between the drop loop and normal byte processing.
  assign w_i_inc = r_i + 8'd1;
  assign w_do_g1 = (r_state == StG1) || ((r_state == StDrop) && (r_phase == 2'd0));
  assign w_do_g2 = (r_state == StG2) || ((r_state == StDrop) && (r_phase == 2'd1));

  // Read addresses depend only on registered state, which keeps the next-state logic loop-free.
  always_comb begin
    w_rd_a_addr = w_i_inc;
    if (r_state == StG3) begin
      w_rd_a_addr = idx_add(r_si, r_sj);
    end
  end

  assign w_rd_b_addr = r_j;

  rc4_sbox u_sbox (
    .clk         (clk),
    .rst         (rst),
    .i_clear     (w_clear),
    .i_rd_a_addr (w_rd_a_addr),
    .o_rd_a_data (w_rd_a_data),
    .i_rd_b_addr (w_rd_b_addr),
    .o_rd_b_data (w_rd_b_data),
    .i_wr_a_en   (w_wr_a_en),
    .i_wr_a_addr (w_wr_a_addr),
    .i_wr_a_data (w_wr_a_data),
    .i_wr_b_en   (w_wr_b_en),
    .i_wr_b_addr (w_wr_b_addr),
    .i_wr_b_data (w_wr_b_data)
  );

  // Next-state, datapath and S-box write control; restart overrides everything.
  always_comb begin
    w_state_d      = r_state;
    w_i_d          = r_i;
    w_j_d          = r_j;
    w_si_d         = r_si;
    w_sj_d         = r_sj;
    w_din_d        = r_din;
    w_dout_d       = r_dout;
    w_dout_valid_d = r_dout_valid;
    w_drop_cnt_d   = r_drop_cnt;
    w_phase_d      = r_phase;
    w_wr_a_en      = 1'b0;
    w_wr_a_addr    = r_i;
    w_wr_a_data    = w_rd_b_data;
    w_wr_b_en      = 1'b0;
    w_wr_b_addr    = r_j;
    w_wr_b_data    = r_si;
    w_clear        = 1'b0;

    case (r_state)
      StLoad: begin
        // Load write and start may coincide: the write still lands this cycle.
        w_wr_a_en   = i_sbox_wr_en;
        w_wr_a_addr = i_sbox_wr_addr;
        w_wr_a_data = i_sbox_wr_data;
        if (i_start) begin
          w_i_d        = '0;
          w_j_d        = '0;
          w_drop_cnt_d = '0;
          w_phase_d    = '0;
          w_state_d    = HasDrop ? StDrop : StIdle;
        end
      end
      StDrop: begin
        unique case (r_phase)
          2'd0: w_phase_d = 2'd1;
          2'd1: w_phase_d = 2'd2;
          default: begin
            // Third cycle of a discarded keystream byte: no lookup, no output.
            w_phase_d = 2'd0;
            if (r_drop_cnt == DropLast) begin
              w_drop_cnt_d = '0;
              w_state_d    = StIdle;
            end else begin
              w_drop_cnt_d = r_drop_cnt + 10'd1;
            end
          end
        endcase
      end
      StIdle: begin
        if (i_din_valid) begin
          w_din_d   = i_din;
          w_state_d = StG1;
        end
      end
      StG1: w_state_d = StG2;
      StG2: w_state_d = StG3;
      StG3: begin
        // Port A reads S[si+sj] after the G2 swap has been written.
        w_dout_d       = r_din ^ w_rd_a_data;
        w_dout_valid_d = 1'b1;
        w_state_d      = StOut;
      end
      StOut: begin
        if (i_dout_ready) begin
          w_dout_valid_d = 1'b0;
          w_state_d      = StIdle;
        end
      end
      default: w_state_d = StLoad;
    endcase

    if (w_do_g1) begin
      w_i_d  = w_i_inc;
      w_si_d = w_rd_a_data;
      w_j_d  = idx_add(r_j, w_rd_a_data);
    end

    // Swap S[i] and S[j]; when i == j both ports write the same value.
    if (w_do_g2) begin
      w_sj_d      = w_rd_b_data;
      w_wr_a_en   = 1'b1;
      w_wr_a_addr = r_i;
      w_wr_a_data = w_rd_b_data;
      w_wr_b_en   = 1'b1;
      w_wr_b_addr = r_j;
      w_wr_b_data = r_si;
    end

    if (i_restart) begin
      w_state_d      = StLoad;
      w_i_d          = '0;
      w_j_d          = '0;
      w_dout_d       = '0;
      w_dout_valid_d = 1'b0;
      w_drop_cnt_d   = '0;
      w_phase_d      = '0;
      w_wr_a_en      = 1'b0;
      w_wr_b_en      = 1'b0;
      w_clear        = 1'b1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= StLoad;
      r_i          <= '0;
      r_j          <= '0;
      r_si         <= '0;
      r_sj         <= '0;
      r_din        <= '0;
      r_dout       <= '0;
      r_dout_valid <= 1'b0;
      r_drop_cnt   <= '0;
      r_phase      <= '0;
    end else begin
      r_state      <= w_state_d;
      r_i          <= w_i_d;
      r_j          <= w_j_d;
      r_si         <= w_si_d;
      r_sj         <= w_sj_d;
      r_din        <= w_din_d;
      r_dout       <= w_dout_d;
      r_dout_valid <= w_dout_valid_d;
      r_drop_cnt   <= w_drop_cnt_d;
      r_phase      <= w_phase_d;
    end
  end

  assign o_din_ready  = (r_state == StIdle);
  assign o_dout_valid = r_dout_valid;
  assign o_dout       = r_dout;
  assign o_busy       = (r_state == StDrop) || (r_state == StG1) || (r_state == StG2) ||
                        (r_state == StG3)   || (r_state == StOut);

endmodule

// File: tb/tb_rc4_prga.sv
// Directed bench for rc4_prga: one instance without drop, one with DROP_N=3,
// checked against hand-computed vectors and a small RC4 reference model.
module tb_rc4_prga;
  import rc4_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       sbox_wr_en, start, restart, din_valid, din_ready;
  logic [7:0] sbox_wr_addr, sbox_wr_data, din, dout;
  logic       dout_valid, dout_ready, busy;

  logic       d_sbox_wr_en, d_start, d_restart, d_din_valid, d_din_ready;
  logic [7:0] d_sbox_wr_addr, d_sbox_wr_data, d_din, d_dout;
  logic       d_dout_valid, d_dout_ready, d_busy;

  rc4_prga #(.DROP_N(0)) dut (
    .clk            (clk),
    .rst            (rst),
    .i_sbox_wr_en   (sbox_wr_en),
    .i_sbox_wr_addr (sbox_wr_addr),
    .i_sbox_wr_data (sbox_wr_data),
    .i_start        (start),
    .i_restart      (restart),
    .i_din_valid    (din_valid),
    .o_din_ready    (din_ready),
    .i_din          (din),
    .o_dout_valid   (dout_valid),
    .i_dout_ready   (dout_ready),
    .o_dout         (dout),
    .o_busy         (busy)
  );

  rc4_prga #(.DROP_N(3)) dut_drop (
    .clk            (clk),
    .rst            (rst),
    .i_sbox_wr_en   (d_sbox_wr_en),
    .i_sbox_wr_addr (d_sbox_wr_addr),
    .i_sbox_wr_data (d_sbox_wr_data),
    .i_start        (d_start),
    .i_restart      (d_restart),
    .i_din_valid    (d_din_valid),
    .o_din_ready    (d_din_ready),
    .i_din          (d_din),
    .o_dout_valid   (d_dout_valid),
    .i_dout_ready   (d_dout_ready),
    .o_dout         (d_dout),
    .o_busy         (d_busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference RC4 model.
  logic [7:0] m_s [256];
  logic [7:0] m_i, m_j;

  task automatic m_identity();
    for (int k = 0; k < 256; k++) m_s[k] = 8'(k);
    m_i = 8'd0;
    m_j = 8'd0;
  endtask

  task automatic m_ksa_key();
    logic [7:0] key [3];
    logic [7:0] j, t;
    key[0] = 8'h4B; key[1] = 8'h65; key[2] = 8'h79;  // "Key"
    j = 8'd0;
    for (int k = 0; k < 256; k++) begin
      j = j + m_s[k] + key[k % 3];
      t = m_s[k]; m_s[k] = m_s[j]; m_s[j] = t;
    end
    m_i = 8'd0;
    m_j = 8'd0;
  endtask

  task automatic m_next(output logic [7:0] ks);
    logic [7:0] t;
    m_i = m_i + 8'd1;
    m_j = m_j + m_s[m_i];
    t = m_s[m_i]; m_s[m_i] = m_s[m_j]; m_s[m_j] = t;
    t = m_s[m_i] + m_s[m_j];
    ks = m_s[t];
  endtask

  task automatic sbox_diff(output int d);
    d = 0;
    for (int k = 0; k < 256; k++) if (dut.u_sbox.r_mem[k] !== m_s[k]) d++;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Write the model S-box into the DUT; start rides on the last write.
  task automatic load_sbox();
    for (int k = 0; k < 256; k++) begin
      sbox_wr_en   = 1'b1;
      sbox_wr_addr = 8'(k);
      sbox_wr_data = m_s[k];
      start        = (k == 255);
      tick();
    end
    sbox_wr_en = 1'b0;
    start      = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, output logic [7:0] r, output int lat);
    int guard;
    guard     = 0;
    r         = 8'h00;
    lat       = -1;
    din       = b;
    din_valid = 1'b1;
    while (!din_ready && guard < 50) begin tick(); guard++; end
    if (!din_ready) begin
      check_eq("din_ready_timeout", din_ready, 1);
      din_valid = 1'b0;
      return;
    end
    tick();
    din_valid = 1'b0;
    lat = 0;
    while (!dout_valid && lat < 50) begin tick(); lat++; end
    if (!dout_valid) begin
      check_eq("dout_timeout", dout_valid, 1);
      return;
    end
    r = dout;
    if (dout_ready) tick();
  endtask

  task automatic pulse_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] r, ks, exp_b, held;
    logic [7:0] pt [9];
    logic [7:0] ct [9];
    int lat, d, guard;

    pt = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    ct = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};

    rst = 1'b0;
    sbox_wr_en = 0; sbox_wr_addr = 0; sbox_wr_data = 0; start = 0; restart = 0;
    din_valid = 0; din = 0; dout_ready = 1;
    d_sbox_wr_en = 0; d_sbox_wr_addr = 0; d_sbox_wr_data = 0; d_start = 0; d_restart = 0;
    d_din_valid = 0; d_din = 0; d_dout_ready = 1;

    // Reset state
    #12;
    check_eq("rst_din_ready", din_ready, 0);
    check_eq("rst_dout_valid", dout_valid, 0);
    check_eq("rst_dout", dout, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_state", dut.r_state, StLoad);
    check_eq("rst_s7", dut.u_sbox.r_mem[7], 8'h07);
    #10 rst = 1'b1;
    tick();

    // Test 4: DROP_N=3 on identity S
    d_start = 1'b1;
    tick();
    d_start = 1'b0;
    for (int k = 0; k < 9; k++) begin
      check_eq("t4_busy_drop", d_busy, 1);
      check_eq("t4_state_drop", dut_drop.r_state, StDrop);
      tick();
    end
    check_eq("t4_busy_after", d_busy, 0);
    check_eq("t4_ready_after", d_din_ready, 1);
    m_identity();
    for (int k = 0; k < 4; k++) m_next(ks);
    d_din = 8'h00;
    d_din_valid = 1'b1;
    tick();
    d_din_valid = 1'b0;
    check_eq("t4_busy_g1", d_busy, 1);
    guard = 0;
    while (!d_dout_valid && guard < 20) begin tick(); guard++; end
    check_eq("t4_dout_valid", d_dout_valid, 1);
    check_eq("t4_dout_model", d_dout, ks);
    check_eq("t4_dout_const", d_dout, 8'h0D);

    // Test 1: identity S, no drop
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("t1_state_idle", dut.r_state, StIdle);
    check_eq("t1_din_ready", din_ready, 1);
    sbox_wr_en = 1'b1; sbox_wr_addr = 8'd5; sbox_wr_data = 8'hAA;
    tick();
    sbox_wr_en = 1'b0;
    check_eq("t1_wr_ignored", dut.u_sbox.r_mem[5], 8'h05);
    send_byte(8'h00, r, lat);
    check_eq("t1_byte0", r, 8'h02);
    check_eq("t1_latency", lat, 3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("t1_start_ignored_i", dut.r_i, 8'h01);
    check_eq("t1_start_ignored_st", dut.r_state, StIdle);
    send_byte(8'h00, r, lat);
    check_eq("t1_byte1", r, 8'h05);
    check_eq("t1_s2", dut.u_sbox.r_mem[2], 8'h03);
    check_eq("t1_s3", dut.u_sbox.r_mem[3], 8'h02);
    check_eq("t1_busy_idle", busy, 0);

    // Test 2: key "Key", encrypt "Plaintext"
    pulse_restart();
    check_eq("t2_state_load", dut.r_state, StLoad);
    m_identity();
    m_ksa_key();
    load_sbox();
    check_eq("t2_state_idle", dut.r_state, StIdle);
    for (int k = 0; k < 9; k++) begin
      send_byte(pt[k], r, lat);
      check_eq($sformatf("t2_ct%0d", k), r, ct[k]);
    end

    // Test 3: decrypt after restart, then a long run past the i/j wrap
    pulse_restart();
    m_identity();
    m_ksa_key();
    load_sbox();
    for (int k = 0; k < 9; k++) begin
      m_next(ks);
      send_byte(ct[k], r, lat);
      check_eq($sformatf("t3_pt%0d", k), r, pt[k]);
    end
    for (int k = 0; k < 300; k++) begin
      din = 8'($urandom);
      exp_b = din;
      m_next(ks);
      send_byte(exp_b, r, lat);
      check_eq($sformatf("t3_run%0d", k), r, exp_b ^ ks);
    end
    check_eq("t3_i", dut.r_i, m_i);
    check_eq("t3_j", dut.r_j, m_j);
    sbox_diff(d);
    check_eq("t3_sbox_diff", d, 0);

    // Test 5: output stall
    dout_ready = 1'b0;
    m_next(ks);
    send_byte(8'h5A, held, lat);
    check_eq("t5_first", held, 8'h5A ^ ks);
    for (int k = 0; k < 10; k++) begin
      tick();
      check_eq("t5_dout_stable", dout, 8'h5A ^ ks);
      check_eq("t5_dout_valid", dout_valid, 1);
      check_eq("t5_din_ready", din_ready, 0);
    end
    sbox_diff(d);
    check_eq("t5_sbox_frozen", d, 0);
    check_eq("t5_i_frozen", dut.r_i, m_i);
    dout_ready = 1'b1;
    tick();
    check_eq("t5_released", dut.r_state, StIdle);
    m_next(ks);
    send_byte(8'hC3, r, lat);
    check_eq("t5_next", r, 8'hC3 ^ ks);

    // Test 6a: restart while in G2
    din = 8'h11;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    guard = 0;
    while (dut.r_state != StG2 && guard < 10) begin tick(); guard++; end
    check_eq("t6_in_g2", dut.r_state, StG2);
    pulse_restart();
    check_eq("t6a_state", dut.r_state, StLoad);
    check_eq("t6a_dout_valid", dout_valid, 0);
    check_eq("t6a_i", dut.r_i, 0);
    check_eq("t6a_j", dut.r_j, 0);
    m_identity();
    sbox_diff(d);
    check_eq("t6a_sbox_identity", d, 0);

    // Test 6b: asynchronous reset while in OUT
    start = 1'b1;
    tick();
    start = 1'b0;
    dout_ready = 1'b0;
    send_byte(8'h00, r, lat);
    check_eq("t6b_in_out", dut.r_state, StOut);
    #2 rst = 1'b0;
    #1;
    check_eq("t6b_state", dut.r_state, StLoad);
    check_eq("t6b_dout_valid", dout_valid, 0);
    check_eq("t6b_dout", dout, 0);
    check_eq("t6b_busy", busy, 0);
    check_eq("t6b_i", dut.r_i, 0);
    check_eq("t6b_j", dut.r_j, 0);
    sbox_diff(d);
    check_eq("t6b_sbox_identity", d, 0);
    #3 rst = 1'b1;
    dout_ready = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
